// File: rtl/fpu_pkg.sv
// Shared FPU definitions: format widths, canonical special values, sequencer states.
package fpu_pkg;

    localparam int SGL_EXP_W  = 8;
    localparam int SGL_FRAC_W = 23;
    localparam int SGL_BIAS   = 127;
    localparam int DBL_EXP_W  = 11;
    localparam int DBL_FRAC_W = 52;
    localparam int DBL_BIAS   = 1023;

    localparam int SGL_EXP_MAX = 2 * SGL_BIAS + 1;
    localparam int DBL_EXP_MAX = 2 * DBL_BIAS + 1;

    // Working mantissa: hidden bit, fraction, then guard/round/sticky in bits 2..0.
    localparam int EXP_W   = 12;
    localparam int MANT_W  = DBL_FRAC_W + 4;
    localparam int SGL_HID = SGL_FRAC_W + 3;
    localparam int DBL_HID = DBL_FRAC_W + 3;

    localparam int SGL_ALIGN_CAP_DEF = 26;
    localparam int DBL_ALIGN_CAP_DEF = 55;

    localparam logic [63:0] SGL_QNAN = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] DBL_QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] SGL_INF  = 64'h0000_0000_7F80_0000;
    localparam logic [63:0] DBL_INF  = 64'h7FF0_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ALIGN,
        ST_SUB,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_t;

    function automatic logic [63:0] inf_word(input logic s, input logic dbl);
        return dbl ? (DBL_INF | {s, 63'd0}) : (SGL_INF | {32'd0, s, 31'd0});
    endfunction

    function automatic logic [63:0] zero_word(input logic s, input logic dbl);
        return dbl ? {s, 63'd0} : {32'd0, s, 31'd0};
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and pack a normalized mantissa with G/R/S into an IEEE word.
module fp_round_pack
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [MANT_W-1:0] mant,
    input  logic              double,
    output logic [63:0]       word
);

    logic                  rnd;
    logic [SGL_FRAC_W+1:0] sig_s;
    logic [DBL_FRAC_W+1:0] sig_d;
    logic [SGL_FRAC_W-1:0] frac_s;
    logic [DBL_FRAC_W-1:0] frac_d;
    logic [EXP_W-1:0]      exp_s;
    logic [EXP_W-1:0]      exp_d;

    // G/R/S and the result LSB sit at the same bit positions for both formats.
    assign rnd = mant[2] & (mant[1] | mant[0] | mant[3]);

    always_comb begin
        sig_s  = {1'b0, mant[SGL_HID:3]} + (SGL_FRAC_W+2)'(rnd);
        sig_d  = {1'b0, mant[DBL_HID:3]} + (DBL_FRAC_W+2)'(rnd);
        frac_s = sig_s[SGL_FRAC_W+1] ? sig_s[SGL_FRAC_W:1] : sig_s[SGL_FRAC_W-1:0];
        frac_d = sig_d[DBL_FRAC_W+1] ? sig_d[DBL_FRAC_W:1] : sig_d[DBL_FRAC_W-1:0];
        exp_s  = exp + EXP_W'(sig_s[SGL_FRAC_W+1]);
        exp_d  = exp + EXP_W'(sig_d[DBL_FRAC_W+1]);

        if (double) begin
            if (exp_d >= EXP_W'(DBL_EXP_MAX))
                word = inf_word(sign, 1'b1);
            else
                word = {sign, exp_d[DBL_EXP_W-1:0], frac_d};
        end else begin
            if (exp_s >= EXP_W'(SGL_EXP_MAX))
                word = inf_word(sign, 1'b0);
            else
                word = {32'd0, sign, exp_s[SGL_EXP_W-1:0], frac_s};
        end
    end

endmodule

// File: rtl/fpu_sub_seq.sv
// Multicycle single/double subtractor (a - b) with bit-serial align and normalize.
module fpu_sub_seq
    import fpu_pkg::*;
#(
    parameter int SGL_ALIGN_CAP = SGL_ALIGN_CAP_DEF,
    parameter int DBL_ALIGN_CAP = DBL_ALIGN_CAP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        double,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    state_t            state;
    logic              dbl_q;
    logic [63:0]       a_q;
    logic [63:0]       b_q;
    logic              sx;
    logic              sy;
    logic              rs;
    logic [EXP_W-1:0]  re;
    logic [MANT_W-1:0] mx;
    logic [MANT_W-1:0] my;
    logic [EXP_W-1:0]  cnt;
    logic              collapse;

    logic              sa, sb, fa_nz, fb_nz;
    logic [EXP_W-1:0]  ea, eb, emax;
    logic [MANT_W-1:0] ma, mb;
    logic              nan_a, nan_b, inf_a, inf_b;

    // Unpack decode; b's sign is flipped so the rest of the datapath is an adder.
    always_comb begin
        if (dbl_q) begin
            sa    = a_q[63];
            sb    = ~b_q[63];
            ea    = EXP_W'(a_q[62:52]);
            eb    = EXP_W'(b_q[62:52]);
            fa_nz = |a_q[DBL_FRAC_W-1:0];
            fb_nz = |b_q[DBL_FRAC_W-1:0];
            ma    = {1'b1, a_q[DBL_FRAC_W-1:0], 3'b000};
            mb    = {1'b1, b_q[DBL_FRAC_W-1:0], 3'b000};
            emax  = EXP_W'(DBL_EXP_MAX);
        end else begin
            sa    = a_q[31];
            sb    = ~b_q[31];
            ea    = EXP_W'(a_q[30:23]);
            eb    = EXP_W'(b_q[30:23]);
            fa_nz = |a_q[SGL_FRAC_W-1:0];
            fb_nz = |b_q[SGL_FRAC_W-1:0];
            ma    = {29'd0, 1'b1, a_q[SGL_FRAC_W-1:0], 3'b000};
            mb    = {29'd0, 1'b1, b_q[SGL_FRAC_W-1:0], 3'b000};
            emax  = EXP_W'(SGL_EXP_MAX);
        end
        if (ea == '0) ma = '0;
        if (eb == '0) mb = '0;
        nan_a = (ea == emax) && fa_nz;
        nan_b = (eb == emax) && fb_nz;
        inf_a = (ea == emax) && !fa_nz;
        inf_b = (eb == emax) && !fb_nz;
    end

    logic             a_big;
    logic [EXP_W-1:0] d;
    logic [EXP_W-1:0] cap;
    logic             special;
    logic [63:0]      special_word;

    assign a_big = (ea >= eb);
    assign d     = a_big ? (ea - eb) : (eb - ea);
    assign cap   = dbl_q ? EXP_W'(DBL_ALIGN_CAP) : EXP_W'(SGL_ALIGN_CAP);

    always_comb begin
        special      = 1'b1;
        special_word = '0;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
            special_word = dbl_q ? DBL_QNAN : SGL_QNAN;
        else if (inf_a)
            special_word = inf_word(sa, dbl_q);
        else if (inf_b)
            special_word = inf_word(sb, dbl_q);
        else
            special = 1'b0;
    end

    logic [MANT_W-1:0] align_m;
    assign align_m = collapse ? MANT_W'(|my)
                              : ({1'b0, my[MANT_W-1:1]} | MANT_W'(my[0]));

    logic [MANT_W:0]   sum_w;
    logic              sub_s, sub_carry, sub_hid, sub_zero;
    logic [MANT_W-1:0] sub_m;
    logic [EXP_W-1:0]  sub_e;

    // Add/subtract magnitudes; a carry-out is folded back with sticky in the same cycle.
    always_comb begin
        if (sx == sy) begin
            sum_w = {1'b0, mx} + {1'b0, my};
            sub_s = sx;
        end else if (mx >= my) begin
            sum_w = {1'b0, mx - my};
            sub_s = sx;
        end else begin
            sum_w = {1'b0, my - mx};
            sub_s = sy;
        end
        sub_zero  = (sum_w == '0);
        sub_carry = dbl_q ? sum_w[MANT_W] : sum_w[SGL_HID+1];
        if (sub_carry) begin
            sub_m = sum_w[MANT_W:1] | MANT_W'(sum_w[0]);
            sub_e = re + 1'b1;
        end else begin
            sub_m = sum_w[MANT_W-1:0];
            sub_e = re;
        end
        sub_hid = dbl_q ? sub_m[DBL_HID] : sub_m[SGL_HID];
    end

    logic [MANT_W-1:0] norm_m;
    logic              norm_hid;
    logic              norm_flush;
    logic [63:0]       rnd_word;

    assign norm_m     = mx << 1;
    assign norm_hid   = dbl_q ? norm_m[DBL_HID] : norm_m[SGL_HID];
    assign norm_flush = (re <= EXP_W'(1));

    fp_round_pack u_round_pack (
        .sign   (rs),
        .exp    (re),
        .mant   (mx),
        .double (dbl_q),
        .word   (rnd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cnt      <= '0;
            collapse <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_UNPACK;
                        busy  <= 1'b1;
                    end
                end
                ST_UNPACK: begin
                    cnt      <= d;
                    collapse <= (d > cap);
                    if (special) begin
                        result <= special_word;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (d != '0) begin
                        state <= ST_ALIGN;
                    end else begin
                        state <= ST_SUB;
                    end
                end
                ST_ALIGN: begin
                    cnt <= cnt - 1'b1;
                    if (collapse || cnt == EXP_W'(1))
                        state <= ST_SUB;
                end
                ST_SUB: begin
                    if (sub_zero) begin
                        result <= '0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (sub_hid) begin
                        state <= ST_ROUND;
                    end else begin
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (norm_flush) begin
                        result <= zero_word(rs, dbl_q);
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (norm_hid) begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    result <= rnd_word;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand datapath carries no reset; it is always reloaded before use.
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (start) begin
                    dbl_q <= double;
                    a_q   <= a;
                    b_q   <= b;
                end
            end
            ST_UNPACK: begin
                if (a_big) begin
                    sx <= sa;
                    sy <= sb;
                    re <= ea;
                    mx <= ma;
                    my <= mb;
                end else begin
                    sx <= sb;
                    sy <= sa;
                    re <= eb;
                    mx <= mb;
                    my <= ma;
                end
            end
            ST_ALIGN: my <= align_m;
            ST_SUB: begin
                rs <= sub_s;
                re <= sub_e;
                mx <= sub_m;
            end
            ST_NORM: begin
                if (!norm_flush) begin
                    mx <= norm_m;
                    re <= re - 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
